// File: rtl/seq_divider.sv
// Iterative unsigned radix-2 restoring divider.
// Produces one quotient bit per clock, with a divide-by-zero fast path and a
// synchronous pipeline-flush abort. Sign handling is left to the requester.
module seq_divider #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_done,
    output logic             div_busy,
    input  logic             refresh_pip_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   q_q, q_d;          // shifting dividend / quotient bits
    // Only the low WIDTH bits of the partial remainder are stored: a kept
    // remainder is always below the divisor, so its top bit is always 0.
    // The trial subtraction itself is still WIDTH+1 bits wide.
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;

    logic [WIDTH:0]     shifted_r;
    logic [WIDTH:0]     trial;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted_r = {r_q, q_q[WIDTH-1]};
        trial     = shifted_r - {1'b0, divisor_q};
    end

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        divisor_d   = divisor_q;
        q_d         = q_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    if (divisor != '0) begin
                        divisor_d = divisor;
                        q_d       = dividend;
                        r_d       = '0;
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = S_CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        state_d     = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted_r[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything, including a start or a DONE-bound step.
        if (refresh_pip_i) begin
            state_d     = S_IDLE;
            divisor_d   = '0;
            q_d         = '0;
            r_d         = '0;
            cnt_d       = '0;
            quotient_d  = '0;
            remainder_d = '0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            divisor_q   <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_busy  = (state_q == S_CALC);
    assign div_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed scenarios plus a
// randomized regression against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         div_start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         refresh_pip_i = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_done;
    logic         div_busy;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .div_start     (div_start),
        .dividend      (dividend),
        .divisor       (divisor),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_done      (div_done),
        .div_busy      (div_busy),
        .refresh_pip_i (refresh_pip_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: plain unsigned division, divide-by-zero convention.
    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] d);
        return (d == '0) ? '1 : a / d;
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] d);
        return (d == '0) ? a : a % d;
    endfunction

    // Issue one start (cycle 0) and observe until div_done or a 40-cycle bound.
    // Operand inputs are scrambled right after the start cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] d,
                          output int done_cyc, output int busy_cnt, output int busy_late);
        @(negedge clk_i);
        dividend  = a;
        divisor   = d;
        div_start = 1'b1;
        done_cyc  = -1;
        busy_cnt  = 0;
        busy_late = 0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                div_start = 1'b0;
                dividend  = $urandom;
                divisor   = $urandom;
            end
            if (div_busy) begin
                busy_cnt++;
                if (c > W) busy_late++;
            end
            if (div_done) done_cyc = c;
        end
    endtask

    // Run one operation and compare results and timing against the model.
    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] d);
        int done_cyc, busy_cnt, busy_late;
        int exp_done, exp_busy;
        logic [W-1:0] eq, er;
        eq = model_q(a, d);
        er = model_r(a, d);
        exp_done = (d == '0) ? 1 : W + 1;
        exp_busy = (d == '0) ? 0 : W;
        run_op(a, d, done_cyc, busy_cnt, busy_late);
        checks++;
        if (done_cyc !== exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (busy_cnt !== exp_busy || busy_late !== 0) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d (late %0d) expected %0d", name, busy_cnt, busy_late, exp_busy);
        end
        checks++;
        if (quotient !== eq) begin
            errors++;
            $display("FAIL %s quotient: a=%h d=%h got %h expected %h", name, a, d, quotient, eq);
        end
        checks++;
        if (remainder !== er) begin
            errors++;
            $display("FAIL %s remainder: a=%h d=%h got %h expected %h", name, a, d, remainder, er);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({quotient, remainder, div_done, div_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h done=%b busy=%b expected all 0",
                     quotient, remainder, div_done, div_busy);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({quotient, remainder, div_done, div_busy} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got q=%h r=%h done=%b busy=%b expected all 0",
                     quotient, remainder, div_done, div_busy);
        end
    endtask

    task automatic test_basic();
        check_op("basic_100_7", 32'd100, 32'd7);
        // done must be a single-cycle pulse; results held afterwards
        repeat (4) begin
            @(negedge clk_i);
            checks++;
            if (div_done !== 1'b0 || div_busy !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
                errors++;
                $display("FAIL hold_after_done: got done=%b busy=%b q=%0d r=%0d expected 0 0 14 2",
                         div_done, div_busy, quotient, remainder);
            end
        end
    endtask

    task automatic test_div_zero();
        check_op("div_by_zero", 32'h0000_1234, 32'd0);
    endtask

    task automatic test_boundaries();
        check_op("max_by_1", 32'hFFFF_FFFF, 32'd1);
        check_op("max_by_msb", 32'hFFFF_FFFF, 32'h8000_0000);
        check_op("small_by_big", 32'd5, 32'd9);
        check_op("zero_by_3", 32'd0, 32'd3);
        check_op("msb_divisor_eq", 32'h8000_0001, 32'h8000_0001);
    endtask

    task automatic test_back_to_back();
        // each call starts in the first idle cycle after the previous done
        check_op("b2b_a", 32'd123456, 32'd789);
        check_op("b2b_b", 32'd77, 32'd0);
        check_op("b2b_c", 32'hDEAD_BEEF, 32'h0001_0000);
    endtask

    task automatic test_start_ignored();
        int done_cyc = -1;
        @(negedge clk_i);
        dividend = 32'd1000; divisor = 32'd10; div_start = 1'b1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk_i);
            div_start = (c == 5);
            if (c == 5) begin dividend = 32'd77; divisor = 32'd3; end
            else if (c > 5) begin dividend = $urandom; divisor = $urandom; end
            if (div_done) done_cyc = c;
        end
        div_start = 1'b0;
        checks++;
        if (done_cyc !== W + 1 || quotient !== 32'd100 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL start_in_calc: got done@%0d q=%0d r=%0d expected done@33 q=100 r=0",
                     done_cyc, quotient, remainder);
        end
    endtask

    // Flush at a given cycle of a 1000/10 operation, then look for stray done.
    task automatic flush_at(input string name, input int flush_cyc);
        int seen_done = 0;
        @(negedge clk_i);
        dividend = 32'd1000; divisor = 32'd10; div_start = 1'b1;
        for (int c = 1; c <= flush_cyc; c++) begin
            @(negedge clk_i);
            div_start = 1'b0;
            if (div_done) seen_done = 1;
        end
        refresh_pip_i = 1'b1;
        @(negedge clk_i);
        refresh_pip_i = 1'b0;
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL %s after_flush: got busy=%b done=%b q=%h r=%h expected 0 0 0 0",
                     name, div_busy, div_done, quotient, remainder);
        end
        repeat (40) begin
            @(negedge clk_i);
            if (div_done || div_busy) seen_done = 1;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL %s stray_activity: got done/busy seen expected none", name);
        end
    endtask

    task automatic test_flush();
        flush_at("flush_c10", 10);
        check_op("after_flush_50_6", 32'd50, 32'd6);
        flush_at("flush_last_step", W);
        // flush together with a start in IDLE: the start is dropped
        @(negedge clk_i);
        dividend = 32'd9; divisor = 32'd4; div_start = 1'b1; refresh_pip_i = 1'b1;
        @(negedge clk_i);
        div_start = 1'b0; refresh_pip_i = 1'b0;
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_start: got busy=%b done=%b expected 0 0", div_busy, div_done);
        end
        check_op("after_flush_start", 32'd9, 32'd4);
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        dividend = 32'd1000; divisor = 32'd10; div_start = 1'b1;
        repeat (15) begin
            @(negedge clk_i);
            div_start = 1'b0;
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, div_done, div_busy} !== '0) begin
            errors++;
            $display("FAIL async_reset: got q=%h r=%h done=%b busy=%b expected all 0",
                     quotient, remainder, div_done, div_busy);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_op("after_reset_7_2", 32'd7, 32'd2);
    endtask

    task automatic test_random();
        logic [W-1:0] a, d;
        int sel, done_cyc, busy_cnt, busy_late;
        logic [63:0] recon;
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 9);
            a = (sel[0]) ? $urandom : W'($urandom_range(0, 1000));
            case (sel)
                0: d = '0;
                1, 2: d = W'($urandom_range(1, 15));
                3: d = $urandom | 32'h8000_0000;
                default: d = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(a, d, done_cyc, busy_cnt, busy_late);
            checks++;
            if (quotient !== model_q(a, d) || remainder !== model_r(a, d)) begin
                errors++;
                $display("FAIL random_result: a=%h d=%h got q=%h r=%h expected q=%h r=%h",
                         a, d, quotient, remainder, model_q(a, d), model_r(a, d));
            end
            checks++;
            if (done_cyc !== ((d == '0) ? 1 : W + 1) || busy_late !== 0) begin
                errors++;
                $display("FAIL random_latency: a=%h d=%h got done@%0d expected done@%0d",
                         a, d, done_cyc, (d == '0) ? 1 : W + 1);
            end
            if (d != '0) begin
                recon = 64'(quotient) * 64'(d) + 64'(remainder);
                checks++;
                if (recon !== 64'(a) || remainder >= d) begin
                    errors++;
                    $display("FAIL random_identity: a=%h d=%h got q*d+r=%h r=%h expected %h with r<d",
                             a, d, recon, remainder, a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_back_to_back();
        test_start_ignored();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
